// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: pipeline MEM stage (port 0) and loader/DMA (port 1) share one data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with port 0 winning.
module mem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [1:0]  state;
  logic        cap_we;
  logic        cap_legal;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        err_q;

  logic        grant;
  logic        sel1;
  logic        serving;
  logic        win_we;
  logic        win_legal;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prio1 set means port 1 wins the next tie; it flips to favour the loser of every grant.
  logic prio1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      prio1 <= 1'b0;
    else if (grant) prio1 <= ~sel1;
  end

  assign sel1 = p1_req & (~p0_req | prio1);
`else
  assign sel1 = p1_req & ~p0_req;
`endif

  assign grant   = ~reset & (state == IDLE) & (p0_req | p1_req);
  assign p0_gnt  = grant & ~sel1;
  assign p1_gnt  = grant & sel1;
  assign serving = (state == SERVE0) | (state == SERVE1);

  always_comb begin
    win_we    = p0_we;
    win_addr  = p0_addr;
    win_wdata = p0_wdata;
    if (sel1) begin
      win_we    = p1_we;
      win_addr  = p1_addr;
      win_wdata = p1_wdata;
    end
    win_legal = (win_addr[1:0] == 2'b00) && ({1'b0, win_addr} < ADDR_LIMIT);
  end

  assign mem_we    = serving & cap_we & cap_legal;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign err       = err_q;

  // Legality and the error flag are resolved at capture, so err is already high in the SERVE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_legal <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      err_q     <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= (state == SERVE0) & ~cap_we;
      p1_rvalid <= (state == SERVE1) & ~cap_we;
      case (state)
        IDLE: begin
          if (grant) begin
            cap_we    <= win_we;
            cap_legal <= win_legal;
            cap_addr  <= win_addr;
            cap_wdata <= win_wdata;
            state     <= sel1 ? SERVE1 : SERVE0;
            if (!win_legal) err_q <= 1'b1;
          end
        end
        SERVE0: begin
          state <= IDLE;
          if (!cap_we) p0_rdata <= cap_legal ? mem_rdata : '0;
        end
        SERVE1: begin
          state <= IDLE;
          if (!cap_we) p1_rdata <= cap_legal ? mem_rdata : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words in the shared data memory; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: p0_req  input  1  pipeline MEM-stage request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt.
REQ-005 Port: p0_we  input  1  1 = write, 0 = read.
REQ-006 Port: p0_addr  input  32  byte address.
REQ-007 Port: p0_wdata  input  32  write data.
REQ-008 Port: p0_gnt  output  1  request accepted this cycle.
REQ-009 Port: p0_rvalid  output  1  one-cycle pulse, p0_rdata valid.
REQ-010 Port: p0_rdata  output  32  read data.
REQ-011 Ports p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata SHALL mirror REQ-004..010 for the loader/DMA requester (port 1).
REQ-012 Port: mem_we  output  1  memory write enable.
REQ-013 Port: mem_addr  output  32  memory byte address.
REQ-014 Port: mem_wdata  output  32  memory write data.
REQ-015 Port: mem_rdata  input  32  combinational memory read data for mem_addr.
REQ-016 Port: err  output  1  sticky out-of-range/misaligned access flag.

Function
REQ-017 FSM states SHALL be IDLE, SERVE0, SERVE1.
REQ-018 In IDLE with any req high, arbiter SHALL assert exactly one gnt combinationally in that cycle, capture the winner's we/addr/wdata into registers, and move to SERVEx on next posedge.
REQ-019 In SERVE0/SERVE1, gnt outputs SHALL be 0; mem_addr/mem_wdata SHALL drive captured values; mem_we SHALL equal captured we AND access legal; next state SHALL be IDLE.
REQ-020 Outside SERVEx, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold the last captured values.
REQ-021 For a read, mem_rdata SHALL be registered at the end of SERVEx; px_rvalid SHALL pulse in the following cycle (gnt at cycle N -> rvalid at N+2); px_rdata SHALL hold until the next read completion on that port.
REQ-022 Writes SHALL produce no rvalid; a write is complete at the end of SERVEx.
REQ-023 Throughput SHALL be one access per two cycles; a request arriving during SERVEx SHALL wait and be arbitrated in the next IDLE cycle.
REQ-024 Access is legal iff addr[1:0]==0 and addr < 4*DEPTH_WORDS; an illegal write SHALL keep mem_we 0, an illegal read SHALL return rdata 0 with normal rvalid timing, and err SHALL set in the SERVE cycle and stay 1 until reset.
REQ-025 Arbitration policy SHALL follow REQ-029/030; with one requester active it SHALL be granted regardless of policy.

Reset
REQ-026 While reset is high, state SHALL be IDLE and p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, err SHALL be 0; p0_rdata, p1_rdata, mem_addr, mem_wdata SHALL be 0.
REQ-027 Reset asserted mid-access SHALL drop the pending access with no memory write and no rvalid.
REQ-028 Round-robin pointer SHALL reset to "port 0 has priority".

Configuration
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted most recently; the pointer updates on every grant.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (fixed priority); no pointer register is instantiated.

Verification
REQ-031 Reset; p0 write addr 0x10 data 0xCAFEBABE, then p0 read 0x10 -> mem_we high one cycle with mem_addr 0x10; p0_rvalid at gnt+2 with p0_rdata 0xCAFEBABE.
REQ-032 p0 and p1 read simultaneously for 4 accesses -> without macro grants P0,P0,P0,P0 while p0 keeps requesting; with macro grants alternate P0,P1,P0,P1.
REQ-033 p1 write addr 0x1000 (DEPTH_WORDS=1024) -> mem_we stays 0, err=1 from SERVE cycle onward; later legal accesses succeed and err stays 1.
REQ-034 p0 read addr 0x6 -> p0_rdata 0, p0_rvalid at gnt+2, err=1.
REQ-035 Assert reset during SERVE1 of a p1 write -> mem_we drops to 0 immediately, no p1_rvalid, state IDLE, err 0.
REQ-036 Back-to-back p0 requests held continuously -> gnt every other cycle, never two consecutive gnt cycles.
